if_fetch_stage: RTL and testbench

- Instruction fetch stage; sits directly upstream of decode/immediate generation. Its inst_code output drives the decoder and immediate-generator input.
- Owns the PC and issues in-order requests to instruction memory with a request/grant handshake.
- Buffers returned words in a small FIFO and presents them to decode with valid/stall flow control.
- Handles branch/jump redirects by flushing buffered and in-flight instructions.

---
 rtl/if_fetch_stage.sv | 157 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers responses for decode.
// Optional macro IF_PERF_CNT_EN adds perf_fetch_bubbles / perf_redirects counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // Handshakes: a request transfers on a cycle with imem_req & imem_gnt; a word reaches
  // decode on a cycle with inst_valid & ~stall; outputs hold while stall is high.
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  output logic [1:0]  fsm_state_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_bubbles,
  output logic [31:0] perf_redirects
`endif
);

  localparam int CW = 4;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW:0]   DEPTH_C = FIFO_DEPTH[CW:0];
  localparam logic [CW-1:0] MAXO_C  = MAX_OUTSTANDING[CW-1:0];
  localparam logic [QW-1:0] QLAST_C = QW'(MAX_OUTSTANDING - 1);
  localparam logic [31:0]   NOP_C   = 32'h0000_0013;

  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] head_q, tail_q;
  logic [QW-1:0] pq_wr_q, pq_rd_q;
  logic [31:0]   code_q [FIFO_DEPTH];
  logic [31:0]   fpc_q  [FIFO_DEPTH];
  logic [31:0]   pq_q   [MAX_OUTSTANDING];

  logic          fetching, gnt, rsp, push, pop;
  logic [CW:0]   occ;
  logic          unused_rpc_lo;

  assign unused_rpc_lo = ^redirect_pc[1:0];
  assign imem_addr     = pc_q;
  assign inst_code     = code_q[head_q];
  assign inst_pc       = fpc_q[head_q];
  assign fsm_state_o   = state_q;

  // A word popped this cycle frees its slot, so a full stream sustains one fetch per cycle.
  always_comb begin
    inst_valid = (cnt_q != '0) && !redirect_valid;
    pop        = inst_valid && !stall;
    occ        = {1'b0, out_q} + {1'b0, cnt_q} - (CW + 1)'(pop);
    fetching   = (state_q != ST_BOOT) && !redirect_valid;
    imem_req   = fetching && (occ < DEPTH_C) && (out_q < MAXO_C);
    gnt        = imem_req && imem_gnt;
    rsp        = imem_rvalid && (out_q != '0);
    push       = rsp && !redirect_valid && (disc_q == '0);
  end

  always_comb begin
    pc_d    = pc_q;
    disc_d  = disc_q;
    state_d = state_q;
    out_d   = out_q + CW'(gnt) - CW'(rsp);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    if (gnt) pc_d = pc_q + 32'd4;
    if (rsp && (disc_q != '0)) disc_d = disc_q - CW'(1);
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_FLUSH: if (disc_d == '0) state_d = ST_RUN;
      default:  state_d = state_q;
    endcase
    // Everything still in flight after this cycle's accounting belongs to the old path.
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      disc_d = out_d;
      cnt_d  = '0;
      if (state_q != ST_BOOT) state_d = (out_d != '0) ? ST_FLUSH : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      pq_wr_q <= '0;
      pq_rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        code_q[i] <= NOP_C;
        fpc_q[i]  <= RESET_PC;
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) pq_q[i] <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      cnt_q   <= cnt_d;
      if (gnt) begin
        pq_q[pq_wr_q] <= pc_q;
        pq_wr_q       <= (pq_wr_q == QLAST_C) ? '0 : pq_wr_q + QW'(1);
      end
      if (rsp) pq_rd_q <= (pq_rd_q == QLAST_C) ? '0 : pq_rd_q + QW'(1);
      if (redirect_valid) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) begin
          code_q[tail_q] <= imem_rdata;
          fpc_q[tail_q]  <= pq_q[pq_rd_q];
          tail_q         <= tail_q + PW'(1);
        end
        if (pop) head_q <= head_q + PW'(1);
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && ({1'b0, cnt_q} == DEPTH_C)));
  assert property (@(posedge clk) disable iff (!rst_n) !(gnt && (out_q >= MAXO_C)));

`ifdef IF_PERF_CNT_EN
  logic [31:0] bub_q, redir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bub_q   <= '0;
      redir_q <= '0;
    end else begin
      if ((state_q == ST_RUN) && !inst_valid && (bub_q != 32'hFFFF_FFFF)) bub_q <= bub_q + 32'd1;
      if (redirect_valid && (redir_q != 32'hFFFF_FFFF)) redir_q <= redir_q + 32'd1;
    end
  end

  assign perf_fetch_bubbles = bub_q;
  assign perf_redirects     = redir_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: fixed vector table, scripted corner sequences, and random traffic
// checked against a queue-level model of the fetch stream.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam int          MAX_OUT    = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, stall, inst_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_code, inst_pc;
  logic [1:0]  fsm_state;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_bubbles, perf_redirects;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat_max = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
    logic        counted;
    logic        keep;
  } mem_ent_t;

  mem_ent_t    mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] next_addr;
  logic        boot;

  typedef struct {
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        rd;
    logic [31:0] rpc;
    logic        st;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_code;
  } vec_t;

  vec_t tbl[20];

  if_fetch_stage #(
    .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst_code(inst_code), .inst_pc(inst_pc),
    .fsm_state_o(fsm_state)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_bubbles(perf_fetch_bubbles), .perf_redirects(perf_redirects)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]};
  endfunction

  function automatic logic [31:0] td(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rdata,
                              input logic rd, input logic [31:0] rpc, input logic st,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rdata = rdata; v.rd = rd; v.rpc = rpc; v.st = st;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_code = td(ep);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_idle();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " imem_req"}, imem_req, 1'b0);
    chk({tag, " inst_valid"}, inst_valid, 1'b0);
    chk({tag, " inst_code"}, inst_code, NOP);
    chk({tag, " inst_pc"}, inst_pc, RESET_PC);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    exp_q.delete();
    mem_q.delete();
    next_addr = RESET_PC;
    @(negedge clk);
    rst_n = 1'b1;
    boot  = 1'b1;
  endtask

  // One cycle: drive at the falling edge, check against the model, then advance the model.
  task automatic step(input logic g, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic rsp_en);
    logic     rv, exp_v, exp_r, pop;
    int       infl;
    mem_ent_t e;
    rv = rsp_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_gnt = g; stall = st; redirect_valid = rd; redirect_pc = rpc;
    imem_rvalid = rv;
    imem_rdata  = rv ? word_of(mem_q[0].addr) : $urandom;
    #1;
    infl = 0;
    for (int i = 0; i < mem_q.size(); i++) if (mem_q[i].counted) infl++;
    exp_v = !rd && (exp_q.size() > 0);
    chk("inst_valid", inst_valid, exp_v);
    if (exp_v) begin
      chk("inst_pc", inst_pc, exp_q[0]);
      chk("inst_code", inst_code, word_of(exp_q[0]));
    end
    pop   = exp_v && !st;
    exp_r = !boot && !rd && ((infl + exp_q.size() - (pop ? 1 : 0)) < FIFO_DEPTH) && (infl < MAX_OUT);
    chk("imem_req", imem_req, exp_r);
    if (exp_r) chk("imem_addr", imem_addr, next_addr);
    if (pop) void'(exp_q.pop_front());
    if (rv) begin
      e = mem_q.pop_front();
      if (e.counted && e.keep && !rd) exp_q.push_back(e.addr);
    end
    if (imem_req && g) begin
      mem_q.push_back('{imem_addr, cyc + int'($urandom_range(1, lat_max)), 1'b1, 1'b1});
      next_addr = next_addr + 32'd4;
    end
    if (rd) begin
      exp_q.delete();
      for (int i = 0; i < mem_q.size(); i++) mem_q[i].keep = 1'b0;
      next_addr = {rpc[31:2], 2'b00};
    end
    boot = 1'b0;
    @(negedge clk);
  endtask

  // Asynchronous reset in mid-cycle with responses pending; stale responses drain afterwards.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check_reset("mid reset");
    exp_q.delete();
    for (int i = 0; i < mem_q.size(); i++) begin
      mem_q[i].counted = 1'b0;
      mem_q[i].keep    = 1'b0;
    end
    next_addr = RESET_PC;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    boot  = 1'b1;
    for (int k = 0; k < 20 && mem_q.size() > 0; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("stale drain left", mem_q.size(), 32'd0);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 0,           0, 0,      0, 0, 0,       0, 0);
    tbl[1]  = mk(1, 0, 0,           0, 0,      0, 1, 'h0,     0, 0);
    tbl[2]  = mk(1, 1, td('h0),     0, 0,      0, 1, 'h4,     0, 0);
    tbl[3]  = mk(1, 1, td('h4),     0, 0,      0, 1, 'h8,     1, 'h0);
    tbl[4]  = mk(1, 1, td('h8),     0, 0,      0, 1, 'hC,     1, 'h4);
    tbl[5]  = mk(1, 1, td('hC),     0, 0,      1, 0, 0,       1, 'h8);
    for (int i = 6; i < 10; i++) tbl[i] = mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 'h8);
    tbl[10] = mk(1, 0, 0,           0, 0,      0, 1, 'h10,    1, 'h8);
    tbl[11] = mk(1, 1, td('h10),    0, 0,      0, 1, 'h14,    1, 'hC);
    tbl[12] = mk(1, 0, 0,           0, 0,      0, 1, 'h18,    1, 'h10);
    tbl[13] = mk(1, 0, 0,           0, 0,      0, 0, 0,       0, 0);
    tbl[14] = mk(1, 0, 0,           1, 'h103,  0, 0, 0,       0, 0);
    tbl[15] = mk(1, 1, td('h14),    0, 0,      0, 0, 0,       0, 0);
    tbl[16] = mk(1, 1, td('h18),    0, 0,      0, 1, 'h100,   0, 0);
    tbl[17] = mk(1, 1, td('h100),   0, 0,      0, 1, 'h104,   0, 0);
    tbl[18] = mk(1, 1, td('h104),   0, 0,      0, 1, 'h108,   1, 'h100);
    tbl[19] = mk(0, 0, 0,           0, 0,      0, 1, 'h10C,   1, 'h104);

    drive_idle();
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      redirect_valid = tbl[i].rd; redirect_pc = tbl[i].rpc; stall = tbl[i].st;
      #1;
      chk($sformatf("tbl[%0d] imem_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("tbl[%0d] imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl[%0d] inst_valid", i), inst_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl[%0d] inst_pc", i), inst_pc, tbl[i].e_pc);
        chk($sformatf("tbl[%0d] inst_code", i), inst_code, tbl[i].e_code);
      end
      @(negedge clk);
    end

    lat_max = 1;
    reset_dut();
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 32'hFFFF_FFFE, 1);
    step(1, 0, 0, 0, 1);
    #1 chk("pc wrap imem_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);

    reset_dut();
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 32'h0000_0200, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1);

    reset_dut();
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h0000_0300, 0);
    step(1, 0, 1, 32'h0000_0400, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    mid_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);

    lat_max = 3;
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) mid_reset();
      else step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 4) != 0));
    end

    $display("final fetch state=%0d", fsm_state);
`ifdef IF_PERF_CNT_EN
    $display("perf bubbles=%0d redirects=%0d", perf_fetch_bubbles, perf_redirects);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
